// File: rtl/nib_bus_arbiter.sv
// Two-port round-robin arbiter for a nibble-wide external memory bus.
// Each transaction takes one address cycle followed by one data cycle.
module nib_bus_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [1:0]        bus_phase,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_oe,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              owner,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                grantValid;
  logic                grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b1;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  // In DATA only the non-owner may be granted, which gives back-to-back alternation.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    grantValid = 1'b0;
    grant      = 1'b0;
    case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          grantValid = 1'b1;
          grant      = (f_req && d_req) ? ~owner_q : d_req;
        end
      end
      ADDR: state_d = DATA;
      DATA: begin
        state_d = IDLE;
        if (owner_q ? f_req : d_req) begin
          grantValid = 1'b1;
          grant      = ~owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grantValid) begin
      state_d = ADDR;
      owner_d = grant;
      addr_d  = grant ? d_addr : f_addr;
      we_d    = grant & d_we;
      wdata_d = grant ? d_wdata : '0;
    end
  end

  // Outputs are forced quiet while reset is held so an aborted transfer never acks.
  always_comb begin
    f_ack     = 1'b0;
    d_ack     = 1'b0;
    rdata     = '0;
    bus_addr  = '0;
    bus_phase = 2'b00;
    bus_wdata = '0;
    bus_oe    = 1'b0;
    if (!rst) begin
      case (state_q)
        ADDR: begin
          bus_phase = 2'b01;
          bus_addr  = addr_q;
        end
        DATA: begin
          bus_phase = {1'b1, we_q};
          bus_addr  = addr_q;
          f_ack     = ~owner_q;
          d_ack     = owner_q;
          if (we_q) begin
            bus_wdata = wdata_q;
            bus_oe    = 1'b1;
          end else begin
            rdata = bus_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign owner = owner_q;
  assign busy  = !rst && (state_q != IDLE);

endmodule

// File: tb/tb_nib_bus_arbiter.sv
// Bench for nib_bus_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic checked against a transaction-level model.
module tb_nib_bus_arbiter;

  typedef struct {
    logic       rst;
    logic       fReq;
    logic [9:0] fAddr;
    logic       dReq;
    logic       dWe;
    logic [9:0] dAddr;
    logic [3:0] dWdata;
    logic [3:0] busRdata;
  } stim_t;

  typedef struct {
    logic       fAck;
    logic       dAck;
    logic [3:0] rdata;
    logic [9:0] busAddr;
    logic [1:0] busPhase;
    logic [3:0] busWdata;
    logic       busOe;
    logic       busy;
    logic       owner;
  } want_t;

  typedef struct {
    stim_t stim;
    want_t want;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       fReq;
  logic [9:0] fAddr;
  logic       fAck;
  logic       dReq;
  logic       dWe;
  logic [9:0] dAddr;
  logic [3:0] dWdata;
  logic       dAck;
  logic [3:0] rdata;
  logic [9:0] busAddr;
  logic [1:0] busPhase;
  logic [3:0] busWdata;
  logic       busOe;
  logic [3:0] busRdata;
  logic       owner;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Transaction model: cycles left in the current transfer (2 = address, 1 = data).
  int         slotsLeft;
  bit         lastGrant;
  logic [9:0] curAddr;
  bit         curWe;
  logic [3:0] curData;
  want_t      lastWant;
  logic       dutFAck;
  logic       dutDAck;

  nib_bus_arbiter #(.ADDR_W(10), .DATA_W(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(fReq), .f_addr(fAddr), .f_ack(fAck),
    .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata), .d_ack(dAck),
    .rdata(rdata), .bus_addr(busAddr), .bus_phase(busPhase),
    .bus_wdata(busWdata), .bus_oe(busOe), .bus_rdata(busRdata),
    .owner(owner), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mkStim(logic r, logic fr, logic [9:0] fa, logic dr, logic dw,
                                   logic [9:0] da, logic [3:0] dd, logic [3:0] br);
    stim_t s;
    s.rst = r; s.fReq = fr; s.fAddr = fa; s.dReq = dr; s.dWe = dw;
    s.dAddr = da; s.dWdata = dd; s.busRdata = br;
    return s;
  endfunction

  function automatic want_t mkWant(logic fa, logic da, logic [3:0] rd, logic [9:0] ba,
                                   logic [1:0] ph, logic [3:0] wd, logic oe, logic bz,
                                   logic ow);
    want_t w;
    w.fAck = fa; w.dAck = da; w.rdata = rd; w.busAddr = ba; w.busPhase = ph;
    w.busWdata = wd; w.busOe = oe; w.busy = bz; w.owner = ow;
    return w;
  endfunction

  // Expected outputs from the model's transfer progress plus the live inputs.
  function automatic want_t modelExpect();
    want_t w;
    w = mkWant(0, 0, 4'h0, 10'h0, 2'b00, 4'h0, 0, 0, lastGrant);
    if (!rst && slotsLeft != 0) begin
      w.busy    = 1'b1;
      w.busAddr = curAddr;
      if (slotsLeft == 2) begin
        w.busPhase = 2'b01;
      end else begin
        w.busPhase = curWe ? 2'b11 : 2'b10;
        w.fAck     = (lastGrant == 1'b0);
        w.dAck     = (lastGrant == 1'b1);
        w.busWdata = curWe ? curData : 4'h0;
        w.busOe    = curWe;
        w.rdata    = curWe ? 4'h0 : busRdata;
      end
    end
    return w;
  endfunction

  task automatic modelStep();
    bit fOk;
    bit dOk;
    bit pick;
    if (rst) begin
      slotsLeft = 0; lastGrant = 1'b1; curAddr = '0; curWe = 0; curData = '0;
    end else if (slotsLeft == 2) begin
      slotsLeft = 1;
    end else begin
      fOk = fReq && !(slotsLeft == 1 && lastGrant == 1'b0);
      dOk = dReq && !(slotsLeft == 1 && lastGrant == 1'b1);
      if (fOk || dOk) begin
        pick      = (fOk && dOk) ? !lastGrant : dOk;
        lastGrant = pick;
        slotsLeft = 2;
        curAddr   = pick ? dAddr : fAddr;
        curWe     = pick ? dWe : 1'b0;
        curData   = pick ? dWdata : 4'h0;
      end else begin
        slotsLeft = 0;
      end
    end
  endtask

  task automatic checkField(input string tag, input string name,
                            input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s: got %0h, expected %0h", tag, name, act, exp);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    rst = s.rst; fReq = s.fReq; fAddr = s.fAddr; dReq = s.dReq; dWe = s.dWe;
    dAddr = s.dAddr; dWdata = s.dWdata; busRdata = s.busRdata;
  endtask

  task automatic checkOutput(input want_t w, input string tag);
    checkField(tag, "f_ack", 16'(fAck), 16'(w.fAck));
    checkField(tag, "d_ack", 16'(dAck), 16'(w.dAck));
    checkField(tag, "rdata", 16'(rdata), 16'(w.rdata));
    checkField(tag, "bus_addr", 16'(busAddr), 16'(w.busAddr));
    checkField(tag, "bus_phase", 16'(busPhase), 16'(w.busPhase));
    checkField(tag, "bus_wdata", 16'(busWdata), 16'(w.busWdata));
    checkField(tag, "bus_oe", 16'(busOe), 16'(w.busOe));
    checkField(tag, "busy", 16'(busy), 16'(w.busy));
    checkField(tag, "owner", 16'(owner), 16'(w.owner));
    dutFAck = fAck;
    dutDAck = dAck;
  endtask

  // One clock: drive after the falling edge, check 1ns later, advance the model on the rising edge.
  task automatic doCycle(input stim_t s, input bit useVec, input want_t vw, input string tag);
    want_t w;
    applyStimulus(s);
    #1;
    w = useVec ? vw : modelExpect();
    checkOutput(w, tag);
    lastWant = w;
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  vec_t  vecs[12];
  want_t noWant;
  stim_t s;
  logic [8:0] fLog;
  logic [8:0] dLog;
  logic       rFReq, rDReq, rDWe;
  logic [9:0] rFAddr, rDAddr;
  logic [3:0] rDWdata;

  initial begin
    noWant = mkWant(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[0]  = '{mkStim(1, 0, 10'h000, 0, 0, 10'h000, 4'h0, 4'h0), mkWant(0, 0, 4'h0, 10'h000, 2'b00, 4'h0, 0, 0, 1)};
    vecs[1]  = '{mkStim(0, 1, 10'h155, 0, 0, 10'h000, 4'h0, 4'h0), mkWant(0, 0, 4'h0, 10'h000, 2'b00, 4'h0, 0, 0, 1)};
    vecs[2]  = '{mkStim(0, 1, 10'h155, 0, 0, 10'h000, 4'h0, 4'h3), mkWant(0, 0, 4'h0, 10'h155, 2'b01, 4'h0, 0, 1, 0)};
    vecs[3]  = '{mkStim(0, 1, 10'h155, 0, 0, 10'h000, 4'h0, 4'hA), mkWant(1, 0, 4'hA, 10'h155, 2'b10, 4'h0, 0, 1, 0)};
    vecs[4]  = '{mkStim(0, 0, 10'h000, 1, 1, 10'h3F0, 4'h7, 4'h5), mkWant(0, 0, 4'h0, 10'h000, 2'b00, 4'h0, 0, 0, 0)};
    vecs[5]  = '{mkStim(0, 0, 10'h000, 1, 1, 10'h3F0, 4'h7, 4'h5), mkWant(0, 0, 4'h0, 10'h3F0, 2'b01, 4'h0, 0, 1, 1)};
    vecs[6]  = '{mkStim(0, 0, 10'h000, 1, 1, 10'h3F0, 4'h7, 4'h5), mkWant(0, 1, 4'h0, 10'h3F0, 2'b11, 4'h7, 1, 1, 1)};
    vecs[7]  = '{mkStim(0, 0, 10'h000, 0, 0, 10'h000, 4'h0, 4'h5), mkWant(0, 0, 4'h0, 10'h000, 2'b00, 4'h0, 0, 0, 1)};
    vecs[8]  = '{mkStim(0, 0, 10'h000, 1, 0, 10'h010, 4'h0, 4'h0), mkWant(0, 0, 4'h0, 10'h000, 2'b00, 4'h0, 0, 0, 1)};
    vecs[9]  = '{mkStim(0, 0, 10'h000, 1, 0, 10'h020, 4'h0, 4'h0), mkWant(0, 0, 4'h0, 10'h010, 2'b01, 4'h0, 0, 1, 1)};
    vecs[10] = '{mkStim(0, 0, 10'h000, 1, 0, 10'h020, 4'h0, 4'h9), mkWant(0, 1, 4'h9, 10'h010, 2'b10, 4'h0, 0, 1, 1)};
    vecs[11] = '{mkStim(0, 0, 10'h000, 0, 0, 10'h020, 4'h0, 4'h9), mkWant(0, 0, 4'h0, 10'h000, 2'b00, 4'h0, 0, 0, 1)};

    slotsLeft = 0; lastGrant = 1'b1; curAddr = '0; curWe = 0; curData = '0;
    applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);

    $display("[TB] directed vector table");
    for (int i = 0; i < 12; i++) doCycle(vecs[i].stim, 1, vecs[i].want, $sformatf("vec%0d", i));

    $display("[TB] contention after reset");
    doCycle(mkStim(1, 0, 0, 0, 0, 0, 0, 0), 0, noWant, "cont_rst");
    for (int k = 0; k < 9; k++) begin
      doCycle(mkStim(0, 1, 10'h0A0 + 10'(k), 1, k[0], 10'h200 + 10'(k), 4'(k), 4'(k + 3)), 0, noWant, "cont");
      fLog[k] = dutFAck;
      dLog[k] = dutDAck;
    end
    checkField("cont", "f_ack_pattern", 16'(fLog), 16'h044);
    checkField("cont", "d_ack_pattern", 16'(dLog), 16'h110);

    $display("[TB] same-port back-to-back");
    doCycle(mkStim(1, 0, 0, 0, 0, 0, 0, 0), 0, noWant, "same_rst");
    for (int k = 0; k < 9; k++) begin
      doCycle(mkStim(0, 0, 0, 1, 0, 10'h111, 4'h0, 4'h6), 0, noWant, "same");
      dLog[k] = dutDAck;
    end
    checkField("same", "d_ack_pattern", 16'(dLog), 16'h124);

    $display("[TB] reset during fetch address cycle");
    doCycle(mkStim(1, 0, 0, 0, 0, 0, 0, 0), 0, noWant, "rmid_rst");
    doCycle(mkStim(0, 1, 10'h2AA, 0, 0, 0, 0, 4'hC), 0, noWant, "rmid_idle");
    doCycle(mkStim(1, 1, 10'h2AA, 0, 0, 0, 0, 4'hC), 0, noWant, "rmid_addr");
    fLog = '0;
    for (int k = 0; k < 3; k++) begin
      doCycle(mkStim(0, 0, 10'h2AA, 0, 0, 0, 0, 4'hC), 0, noWant, "rmid_after");
      fLog[k] = dutFAck;
    end
    checkField("rmid", "f_ack_seen", 16'(fLog), 16'h000);

    $display("[TB] request dropped mid-transaction");
    dLog = '0;
    doCycle(mkStim(0, 0, 0, 1, 1, 10'h0F5, 4'hE, 4'h1), 0, noWant, "drop");
    for (int k = 0; k < 3; k++) begin
      doCycle(mkStim(0, 0, 0, 0, 0, 10'h3FF, 4'h0, 4'h1), 0, noWant, "drop");
      dLog[k] = dutDAck;
    end
    checkField("drop", "d_ack_pattern", 16'(dLog), 16'h002);

    $display("[TB] randomized traffic");
    rFReq = 0; rDReq = 0; rDWe = 0; rFAddr = '0; rDAddr = '0; rDWdata = '0;
    for (int n = 0; n < 400; n++) begin
      if (lastWant.fAck || ($urandom % 30 == 0)) rFReq = 0;
      else if (!rFReq && ($urandom % 3 == 0)) begin
        rFReq = 1; rFAddr = 10'($urandom);
      end
      if (lastWant.dAck || ($urandom % 30 == 0)) rDReq = 0;
      else if (!rDReq && ($urandom % 3 == 0)) begin
        rDReq = 1; rDWe = 1'($urandom); rDAddr = 10'($urandom); rDWdata = 4'($urandom);
      end
      s = mkStim(($urandom % 50 == 0), rFReq, rFAddr, rDReq, rDWe, rDAddr, rDWdata, 4'($urandom));
      doCycle(s, 0, noWant, $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
